// File: rtl/lfsr_step_gen_if.sv
// Button/step bundle between the push-button front panel and the step generator.
// The master side drives the raw active-low keys and receives the step pulse
// and mode indication; the generator itself is the slave.
interface lfsr_step_gen_if;
  logic key_n;
  logic mode_key_n;
  logic step;
  logic auto_mode;

  modport master (
    output key_n,
    output mode_key_n,
    input  step,
    input  auto_mode
  );

  modport slave (
    input  key_n,
    input  mode_key_n,
    output step,
    output auto_mode
  );
endinterface

// File: rtl/lfsr_step_gen.sv
// Step-pulse generator for the LFSR display stage: two debounced active-low
// buttons, manual single-step or periodic auto-step, mode toggled by a button.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_MANUAL | one step pulse per debounced step-key press (reset state)
// ST_AUTO   | step pulse every AUTO_DIV cycles, step-key presses ignored
module lfsr_step_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 25000000
) (
  input logic            clk,
  input logic            rst,
  lfsr_step_gen_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

  // Bit 0 is the step key, bit 1 the mode key.
  logic [1:0]         raw_n;
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         stable_q, stable_d;
  logic [1:0]         prev_q, prev_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          auto_wrap;
  logic          step_q, step_d;
  logic          auto_mode_q, auto_mode_d;

  assign raw_n = {bus.mode_key_n, bus.key_n};

  // Synchronizers, debounce counters and press detection for both keys.
  always_comb begin
    sync1_d  = raw_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // Released (1) to pressed (0) on the stable level; releases are ignored.
    press = prev_q & ~stable_q;
  end

  // Mode FSM next state: a mode press toggles between MANUAL and AUTO.
  always_comb begin
    state_d = state_q;
    if (press[1]) begin
      state_d = (state_q == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
    end
  end

  // Auto divider: runs only while staying in AUTO, so it enters at 0 and
  // any partial period is dropped on exit (including the wrap edge itself).
  always_comb begin
    div_d     = '0;
    auto_wrap = 1'b0;
    if (state_q == ST_AUTO && !press[1]) begin
      if (div_q == DIV_LAST) begin
        auto_wrap = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // Outputs: manual pulse from a step press, auto pulse from a divider wrap.
  always_comb begin
    step_d      = ((state_q == ST_MANUAL) && press[0]) || auto_wrap;
    auto_mode_d = (state_d == ST_AUTO);
  end

  // All state registers; reset returns the keys to released and clears progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      stable_q    <= 2'b11;
      prev_q      <= 2'b11;
      cnt_q       <= '0;
      state_q     <= ST_MANUAL;
      div_q       <= '0;
      step_q      <= 1'b0;
      auto_mode_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      div_q       <= div_d;
      step_q      <= step_d;
      auto_mode_q <= auto_mode_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.auto_mode = auto_mode_q;
endmodule

// File: tb/tb_lfsr_step_gen.sv
// Self-checking bench for lfsr_step_gen with DEBOUNCE_CYCLES=4, AUTO_DIV=8.
// Expected step edges are queued when stimulus is applied; a negedge monitor
// matches every observed pulse against the queue.
module tb_lfsr_step_gen;
  logic clk;
  logic rst;
  int   edge_n;
  int   n_cmp;
  int   n_bad;
  int   exp_q[$];

  lfsr_step_gen_if bus();

  lfsr_step_gen #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_DIV       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // Step monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0] < edge_n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL step_missed: step low at edge %0d, required high", exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (bus.step === 1'b1) begin
      n_cmp++;
      if (exp_q.size() > 0 && exp_q[0] == edge_n) begin
        void'(exp_q.pop_front());
      end else begin
        n_bad++;
        $display("FAIL step_unexpected: step high at edge %0d, required low", edge_n);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  typedef struct {
    int low_cycles;
    int high_cycles;
    bit exp_pulse;
  } press_vec_t;

  press_vec_t vecs[6];
  int k, a, x, k2, r;

  initial begin
    vecs[0] = '{low_cycles: 20, high_cycles: 20, exp_pulse: 1'b1};
    vecs[1] = '{low_cycles: 3,  high_cycles: 20, exp_pulse: 1'b0};
    vecs[2] = '{low_cycles: 4,  high_cycles: 20, exp_pulse: 1'b1};
    vecs[3] = '{low_cycles: 1,  high_cycles: 20, exp_pulse: 1'b0};
    vecs[4] = '{low_cycles: 8,  high_cycles: 20, exp_pulse: 1'b1};
    vecs[5] = '{low_cycles: 5,  high_cycles: 20, exp_pulse: 1'b1};

    edge_n         = 0;
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    bus.key_n      = 1'b1;
    bus.mode_key_n = 1'b1;

    // Reset: three cycles, outputs low throughout.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_step", bus.step, 0);
      check("reset_auto_mode", bus.auto_mode, 0);
    end
    rst = 1'b0;
    tick(50);
    check("idle_auto_mode", bus.auto_mode, 0);

    // Manual presses of various lengths: 3 samples is too short, 4 is enough.
    for (int i = 0; i < 6; i++) begin
      k         = edge_n;
      bus.key_n = 1'b0;
      if (vecs[i].exp_pulse) exp_q.push_back(k + 7);
      tick(vecs[i].low_cycles);
      bus.key_n = 1'b1;
      tick(vecs[i].high_cycles);
      check("vec_auto_mode", bus.auto_mode, 0);
      check("vec_pending", exp_q.size(), 0);
    end

    // Bounce: 0,0,0,1 five times, then a held 0.
    for (int i = 0; i < 5; i++) begin
      bus.key_n = 1'b0;
      tick(3);
      bus.key_n = 1'b1;
      tick(1);
    end
    k         = edge_n;
    bus.key_n = 1'b0;
    exp_q.push_back(k + 7);
    wait_to(k + 6);
    check("bounce_pre_step", bus.step, 0);
    tick(1);
    check("bounce_step", bus.step, 1);
    tick(1);
    check("bounce_step_fall", bus.step, 0);
    tick(13);
    bus.key_n = 1'b1;
    tick(20);
    check("bounce_pending", exp_q.size(), 0);

    // Auto mode entry and periodic pulses; step-key press inside AUTO ignored.
    k              = edge_n;
    bus.mode_key_n = 1'b0;
    a              = k + 7;
    for (int n = 1; n <= 4; n++) exp_q.push_back(a + 8 * n);
    wait_to(a - 1);
    check("auto_pre_rise", bus.auto_mode, 0);
    tick(1);
    check("auto_rise", bus.auto_mode, 1);
    check("auto_rise_step", bus.step, 0);
    wait_to(a + 13);
    bus.mode_key_n = 1'b1;
    wait_to(a + 18);
    bus.key_n = 1'b0;
    wait_to(a + 28);
    bus.key_n = 1'b1;
    check("auto_hold", bus.auto_mode, 1);

    // Mode exit timed on the wrap edge: no pulse there, none afterwards.
    x = a + 40;
    wait_to(x - 7);
    bus.mode_key_n = 1'b0;
    wait_to(x - 1);
    check("exit_pre_fall", bus.auto_mode, 1);
    tick(1);
    check("exit_fall", bus.auto_mode, 0);
    check("exit_no_step", bus.step, 0);
    wait_to(x + 5);
    bus.mode_key_n = 1'b1;
    wait_to(x + 30);
    check("exit_pending", exp_q.size(), 0);
    check("exit_manual", bus.auto_mode, 0);

    // Simultaneous presses in MANUAL: pulse and AUTO on the same edge.
    wait_to(x + 40);
    k2             = edge_n;
    bus.key_n      = 1'b0;
    bus.mode_key_n = 1'b0;
    exp_q.push_back(k2 + 7);
    exp_q.push_back(k2 + 15);
    wait_to(k2 + 6);
    check("simul_pre_auto", bus.auto_mode, 0);
    tick(1);
    check("simul_auto", bus.auto_mode, 1);
    check("simul_step", bus.step, 1);
    wait_to(k2 + 12);
    bus.mode_key_n = 1'b1;

    // Reset three edges into the second auto period, step key still held.
    wait_to(k2 + 17);
    rst = 1'b1;
    tick(1);
    check("mid_reset_step", bus.step, 0);
    check("mid_reset_auto", bus.auto_mode, 0);
    tick(2);
    rst = 1'b0;
    r   = edge_n;
    exp_q.push_back(r + 7);
    wait_to(r + 6);
    check("rst_rel_pre_step", bus.step, 0);
    tick(1);
    check("rst_rel_step", bus.step, 1);
    check("rst_rel_auto", bus.auto_mode, 0);
    tick(10);
    bus.key_n = 1'b1;
    tick(30);
    check("final_auto_mode", bus.auto_mode, 0);
    check("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
